// File: rtl/step_ram_loader.sv
// Step RAM loader: takes a word-count header followed by 2N 32-bit halves and
// packs them (low half first) into N 64-bit RAM words at addresses 0..N-1.
module step_ram_loader #(
  parameter int RAM_ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH        = 64,
  parameter int IO_WIDTH          = 32,
  parameter int RAM_DEPTH         = 200
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Load_Start,
  input  logic                         INT,
  input  logic [IO_WIDTH-1:0]          IO_Data,
  output logic                         RAM_WR_Enable,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
  output logic [DATA_WIDTH-1:0]        RAM_WR_Data,
  output logic                         Busy,
  output logic                         Load_Done,
  output logic                         Process_Start,
  output logic                         Error_Flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOW, S_HIGH, S_DONE, S_ERROR
  } state_t;

  localparam logic [RAM_ADDRESS_WIDTH-1:0] DEPTH_L = RAM_ADDRESS_WIDTH'(RAM_DEPTH);
  localparam logic [RAM_ADDRESS_WIDTH-1:0] ONE_L   = RAM_ADDRESS_WIDTH'(1);

  state_t                         state, state_nxt;
  logic [RAM_ADDRESS_WIDTH-1:0]   n_words;
  logic [RAM_ADDRESS_WIDTH-1:0]   word_cnt;
  logic [RAM_ADDRESS_WIDTH-1:0]   cnt_inc;
  logic [IO_WIDTH-1:0]            low_half;
  logic [RAM_ADDRESS_WIDTH-1:0]   hdr_n;
  logic [IO_WIDTH-RAM_ADDRESS_WIDTH-1:0] hdr_hi;
  logic                           hdr_bad;
  logic                           hdr_take;
  logic                           low_take;
  logic                           write_fire;

  assign hdr_n      = IO_Data[RAM_ADDRESS_WIDTH-1:0];
  assign hdr_hi     = IO_Data[IO_WIDTH-1:RAM_ADDRESS_WIDTH];
  assign hdr_bad    = (hdr_n == '0) || (hdr_n > DEPTH_L) || (|hdr_hi);
  assign cnt_inc    = word_cnt + ONE_L;
  assign hdr_take   = (state == S_HEADER) && INT && !hdr_bad;
  assign low_take   = (state == S_LOW) && INT;
  assign write_fire = (state == S_HIGH) && INT;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Load_Start) state_nxt = S_HEADER;
      S_HEADER: if (INT)        state_nxt = hdr_bad ? S_ERROR : S_LOW;
      S_LOW:    if (INT)        state_nxt = S_HIGH;
      S_HIGH:   if (INT)        state_nxt = (cnt_inc == n_words) ? S_DONE : S_LOW;
      S_DONE,
      S_ERROR:  if (Load_Start) state_nxt = S_HEADER;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the
  // final RAM write issued on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n_words        <= '0;
      word_cnt       <= '0;
      low_half       <= '0;
      RAM_WR_Enable  <= 1'b0;
      RAM_WR_Address <= '0;
      RAM_WR_Data    <= '0;
      Busy           <= 1'b0;
      Load_Done      <= 1'b0;
      Process_Start  <= 1'b0;
      Error_Flag     <= 1'b0;
    end else begin
      if (hdr_take) begin
        n_words  <= hdr_n;
        word_cnt <= '0;
      end
      if (low_take) low_half <= IO_Data;
      RAM_WR_Enable <= write_fire;
      if (write_fire) begin
        RAM_WR_Address <= word_cnt;
        RAM_WR_Data    <= {IO_Data, low_half};
        word_cnt       <= cnt_inc;
      end
      Busy          <= (state_nxt == S_HEADER) || (state_nxt == S_LOW) || (state_nxt == S_HIGH);
      Load_Done     <= (state_nxt == S_DONE);
      Process_Start <= (state_nxt == S_DONE) && (state != S_DONE);
      Error_Flag    <= (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_step_ram_loader.sv
// Directed/randomized bench for step_ram_loader with a queue-based model of
// the expected RAM image built from the halves that were sent.
module tb_step_ram_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Load_Start = 1'b0;
  logic        INT = 1'b0;
  logic [31:0] IO_Data = '0;
  logic        RAM_WR_Enable;
  logic [12:0] RAM_WR_Address;
  logic [63:0] RAM_WR_Data;
  logic        Busy, Load_Done, Process_Start, Error_Flag;

  int errors = 0;
  int checks = 0;

  step_ram_loader #(
    .RAM_ADDRESS_WIDTH(13), .DATA_WIDTH(64), .IO_WIDTH(32), .RAM_DEPTH(200)
  ) dut (
    .CLK(CLK), .RST(RST), .Load_Start(Load_Start), .INT(INT), .IO_Data(IO_Data),
    .RAM_WR_Enable(RAM_WR_Enable), .RAM_WR_Address(RAM_WR_Address),
    .RAM_WR_Data(RAM_WR_Data), .Busy(Busy), .Load_Done(Load_Done),
    .Process_Start(Process_Start), .Error_Flag(Error_Flag)
  );

  always #5 CLK = ~CLK;

  // Write monitor, sampled 1 time unit after each rising edge.
  logic [12:0] wa_q[$];
  logic [63:0] wd_q[$];
  int          ps_cnt = 0;
  bit          ps_no_we = 1'b0;
  bit          we_consec = 1'b0;
  bit          prev_we = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (RAM_WR_Enable) begin
      wa_q.push_back(RAM_WR_Address);
      wd_q.push_back(RAM_WR_Data);
      if (prev_we) we_consec = 1'b1;
    end
    if (Process_Start) begin
      ps_cnt++;
      if (!RAM_WR_Enable) ps_no_we = 1'b1;
    end
    prev_we = RAM_WR_Enable;
  end

  logic [31:0] hq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; called and returns at a falling edge.
  task automatic step(input logic ls, input logic it, input logic [31:0] d);
    Load_Start = ls; INT = it; IO_Data = d;
    @(negedge CLK);
    Load_Start = 1'b0; INT = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  // Send every half in hq, with up to maxgap idle cycles before each.
  task automatic send_halves(input int maxgap);
    for (int i = 0; i < hq.size(); i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      step(1'b0, 1'b1, hq[i]);
    end
  endtask

  // Model: word k = {half[2k+1], half[2k]} at address k, in order, after base.
  task automatic check_image(input string tag, input int base);
    int nw;
    nw = hq.size() / 2;
    chk({tag, "_count"}, 64'(wa_q.size()), 64'(base + nw));
    for (int k = 0; k < nw && (base + k) < wa_q.size(); k++) begin
      chk({tag, "_addr"}, 64'(wa_q[base+k]), 64'(k));
      chk({tag, "_data"}, wd_q[base+k], {hq[2*k+1], hq[2*k]});
    end
  endtask

  function automatic logic [63:0] outs_all();
    return {RAM_WR_Enable, 1'b0, RAM_WR_Address, 1'b0, Busy, Load_Done, Process_Start, Error_Flag}
           | ((|RAM_WR_Data) ? 64'h1_0000_0000 : 64'h0);
  endfunction

  initial begin
    int base, ps0;

    // Reset state
    @(negedge CLK); @(negedge CLK);
    chk("reset_outputs", outs_all(), 64'h0);
    RST = 1'b1;
    @(negedge CLK);

    // INT in IDLE is ignored
    base = wa_q.size();
    step(1'b0, 1'b1, 32'h2);
    idle(1);
    chk("idle_int_busy", Busy, 1'b0);
    chk("idle_int_nowr", 64'(wa_q.size()), 64'(base));

    // Basic 2-word load, back-to-back halves
    base = wa_q.size(); ps0 = ps_cnt;
    step(1'b1, 1'b0, 32'h0);
    chk("start_busy", Busy, 1'b1);
    step(1'b0, 1'b1, 32'd2);
    hq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_halves(0);
    chk("basic_ps", Process_Start, 1'b1);
    chk("basic_done", Load_Done, 1'b1);
    chk("basic_busy", Busy, 1'b0);
    chk("basic_last_addr", RAM_WR_Address, 13'd1);
    chk("basic_last_data", RAM_WR_Data, 64'h4444444433333333);
    idle(1);
    chk("basic_ps_off", Process_Start, 1'b0);
    chk("basic_done_hold", Load_Done, 1'b1);
    chk("basic_we_off", RAM_WR_Enable, 1'b0);
    chk("basic_addr_hold", RAM_WR_Address, 13'd1);
    chk("basic_ps_count", 64'(ps_cnt - ps0), 64'd1);
    check_image("basic", base);

    // INT in DONE is ignored
    base = wa_q.size();
    step(1'b0, 1'b1, 32'h1);
    idle(1);
    chk("done_int_done", Load_Done, 1'b1);
    chk("done_int_nowr", 64'(wa_q.size()), 64'(base));

    // Header errors: zero, too large, stray upper bits
    base = wa_q.size();
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'd0);
    chk("hdr0_err", Error_Flag, 1'b1);
    chk("hdr0_done_clr", Load_Done, 1'b0);
    step(1'b0, 1'b1, 32'h5);
    step(1'b0, 1'b1, 32'h6);
    chk("err_int_ignored", Error_Flag, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    chk("err_clear", Error_Flag, 1'b0);
    step(1'b0, 1'b1, 32'd201);
    chk("hdr201_err", Error_Flag, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0001_0002);
    chk("hdr_upper_err", Error_Flag, 1'b1);
    idle(2);
    chk("err_nowr", 64'(wa_q.size()), 64'(base));

    // Recovery from ERROR with a 1-word load
    step(1'b1, 1'b0, 32'h0);
    chk("recover_err_clr", Error_Flag, 1'b0);
    step(1'b0, 1'b1, 32'd1);
    hq = '{32'hA, 32'hB};
    send_halves(0);
    chk("recover_done", Load_Done, 1'b1);
    chk("recover_data", RAM_WR_Data, 64'h0000000B0000000A);
    check_image("recover", base);

    // Full-depth load with random gaps
    base = wa_q.size(); ps0 = ps_cnt;
    hq.delete();
    for (int i = 0; i < 400; i++) hq.push_back($urandom);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'd200);
    for (int i = 0; i < 399; i++) begin
      idle($urandom_range(0, 3));
      step(1'b0, 1'b1, hq[i]);
    end
    idle($urandom_range(0, 3));
    chk("full_busy_before", Busy, 1'b1);
    chk("full_done_before", Load_Done, 1'b0);
    step(1'b0, 1'b1, hq[399]);
    chk("full_busy_after", Busy, 1'b0);
    chk("full_done_after", Load_Done, 1'b1);
    idle(1);
    chk("full_ps_count", 64'(ps_cnt - ps0), 64'd1);
    check_image("full", base);

    // Asynchronous reset mid-load
    base = wa_q.size();
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'd3);
    hq = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    send_halves(0);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_outputs", outs_all(), 64'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_one_write", 64'(wa_q.size()), 64'(base + 1));
    if (wa_q.size() > base) begin
      chk("rst_addr0", 64'(wa_q[base]), 64'd0);
      chk("rst_data0", wd_q[base], 64'hC0DE0002C0DE0001);
    end

    // Load_Start during LOW is ignored
    base = wa_q.size();
    hq = '{$urandom, $urandom};
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk("low_ls_busy", Busy, 1'b1);
    chk("low_ls_nowr", 64'(wa_q.size()), 64'(base));
    send_halves(1);
    chk("low_ls_done", Load_Done, 1'b1);
    check_image("low_ls", base);

    // Load_Start with INT in DONE: INT is not a header
    base = wa_q.size();
    step(1'b1, 1'b1, 32'd5);
    chk("ls_int_busy", Busy, 1'b1);
    chk("ls_int_done_clr", Load_Done, 1'b0);
    step(1'b0, 1'b1, 32'd1);
    hq = '{$urandom, $urandom};
    send_halves(0);
    chk("ls_int_done", Load_Done, 1'b1);
    check_image("ls_int", base);

    idle(2);
    chk("we_single_cycle", we_consec, 1'b0);
    chk("ps_with_write", ps_no_we, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
